// File: rtl/mult_hilo_unit.sv
// Iterative MULT/MULTU unit that owns the architectural HI/LO registers and serves MFHI/MFLO reads.
// Defining MULT_RADIX4_EN retires two multiplier bits per cycle; results are identical in either build.
module mult_hilo_unit #(
   parameter int         WIDTH    = 32,
   parameter logic [5:0] MULT_OP  = 6'b011000,
   parameter logic [5:0] MULTU_OP = 6'b011001
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             issue,
   input  logic [5:0]       op_sel,
   input  logic             hi_en,
   input  logic             lo_en,
   input  logic [1:0]       alu_lo_hi,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic [WIDTH-1:0] lohi_data
);

`ifdef MULT_RADIX4_EN
   localparam int ITERS = WIDTH / 2;
`else
   localparam int ITERS = WIDTH;
`endif
   localparam int CW = $clog2(ITERS) + 1;

   typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

   state_t             state;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] acc;
   logic               sign;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;

   logic               mult_req;
   logic               is_signed;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [2*WIDTH-1:0] acc_next;
   logic [WIDTH-1:0]   mplier_next;
   logic [2*WIDTH-1:0] product;

   assign mult_req  = issue && hi_en && lo_en && (op_sel == MULT_OP || op_sel == MULTU_OP);
   assign is_signed = (op_sel == MULT_OP);
   // Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which still fits unsigned in WIDTH bits.
   assign a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
   assign b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;

`ifdef MULT_RADIX4_EN
   logic [WIDTH+1:0] pp;
   logic [WIDTH+1:0] add_sum;

   always_comb begin
      pp = '0;
      case (mplier[1:0])
         2'b01:   pp = {2'b00, mcand};
         2'b10:   pp = {1'b0, mcand, 1'b0};
         2'b11:   pp = {2'b00, mcand} + {1'b0, mcand, 1'b0};
         default: pp = '0;
      endcase
   end

   assign add_sum     = {2'b00, acc[2*WIDTH-1:WIDTH]} + pp;
   assign acc_next    = {add_sum, acc[WIDTH-1:2]};
   assign mplier_next = mplier >> 2;
`else
   logic [WIDTH:0] add_sum;

   assign add_sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
   assign acc_next    = {add_sum, acc[WIDTH-1:1]};
   assign mplier_next = mplier >> 1;
`endif

   assign product = sign ? -acc : acc;

   // Only instructions that touch HI/LO are held while a multiply is in flight.
   assign stall  = busy && issue && (mult_req || alu_lo_hi == 2'b01 || alu_lo_hi == 2'b10);
   assign hi_out = hi_q;
   assign lo_out = lo_q;

   always_comb begin
      lohi_data = '0;
      case (alu_lo_hi)
         2'b01:   lohi_data = lo_q;
         2'b10:   lohi_data = hi_q;
         default: lohi_data = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         sign   <= 1'b0;
         cnt    <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (mult_req && !flush) begin
                  mcand  <= a_mag;
                  mplier <= b_mag;
                  sign   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                  acc    <= '0;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               if (flush) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  acc    <= acc_next;
                  mplier <= mplier_next;
                  cnt    <= cnt + 1'b1;
                  if (cnt == CW'(ITERS - 1)) state <= WB;
               end
            end
            WB: begin
               busy  <= 1'b0;
               state <= IDLE;
               if (!flush) begin
                  hi_q <= product[2*WIDTH-1:WIDTH];
                  lo_q <= product[WIDTH-1:0];
                  done <= 1'b1;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Directed-vector bench for mult_hilo_unit: products, latency, stall rules, flush/reset aborts, back-to-back issue.
module tb_mult_hilo_unit;
   localparam int W = 32;
`ifdef MULT_RADIX4_EN
   localparam int ITERS = W / 2;
`else
   localparam int ITERS = W;
`endif
   localparam logic [5:0] MULT  = 6'b011000;
   localparam logic [5:0] MULTU = 6'b011001;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         issue = 1'b0;
   logic [5:0]   op_sel = '0;
   logic         hi_en = 1'b0;
   logic         lo_en = 1'b0;
   logic [1:0]   alu_lo_hi = 2'b00;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         flush = 1'b0;
   logic         busy, stall, done;
   logic [W-1:0] hi_out, lo_out, lohi_data;

   int n_cmp = 0;
   int n_bad = 0;

   mult_hilo_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .issue(issue), .op_sel(op_sel), .hi_en(hi_en), .lo_en(lo_en),
      .alu_lo_hi(alu_lo_hi), .a(a), .b(b), .flush(flush), .busy(busy), .stall(stall),
      .done(done), .hi_out(hi_out), .lo_out(lo_out), .lohi_data(lohi_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      issue = 0; op_sel = '0; hi_en = 0; lo_en = 0; alu_lo_hi = 2'b00; flush = 0;
   endtask

   task automatic present_mult(input logic [5:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
      issue = 1; op_sel = op; hi_en = 1; lo_en = 1; a = av; b = bv; alu_lo_hi = 2'b00;
   endtask

   // Starts at the sample point after the accept edge; counts busy cycles until done.
   task automatic wait_done(output int cycles, output bit ok);
      cycles = 0;
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         if (done === 1'b1) begin ok = 1; break; end
         if (busy === 1'b1) cycles++;
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1; idle_inputs();
      tick(); tick();
      rst = 0;
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", done); end
      n_cmp++; if (hi_out !== '0) begin n_bad++; $display("FAIL reset_hi got=%h want=0", hi_out); end
      n_cmp++; if (lo_out !== '0) begin n_bad++; $display("FAIL reset_lo got=%h want=0", lo_out); end
   endtask

   task automatic run_mult(input string name, input logic [5:0] op, input logic [W-1:0] av,
                           input logic [W-1:0] bv, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
      int  cyc;
      bit  ok;
      present_mult(op, av, bv);
      tick();
      idle_inputs();
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL %s_busy_start got=%b want=1", name, busy); end
      wait_done(cyc, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL %s_timeout got=no_done want=done", name); end
      n_cmp++; if (cyc != ITERS + 1) begin n_bad++; $display("FAIL %s_latency got=%0d want=%0d", name, cyc, ITERS + 1); end
      n_cmp++; if (hi_out !== exp_hi) begin n_bad++; $display("FAIL %s_hi got=%h want=%h", name, hi_out, exp_hi); end
      n_cmp++; if (lo_out !== exp_lo) begin n_bad++; $display("FAIL %s_lo got=%h want=%h", name, lo_out, exp_lo); end
      tick();
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL %s_done_pulse got=%b want=0", name, done); end
   endtask

   task automatic test_multu();
      run_mult("multu_ffff_x2", MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE);
      run_mult("multu_max_sq", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
   endtask

   task automatic test_mult_signed();
      run_mult("mult_m3_x5", MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
      run_mult("mult_min_sq", MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
   endtask

   task automatic test_mflo_stall();
      bit stall_ok = 1;
      bit ok = 0;
      present_mult(MULTU, 32'h00010000, 32'h00010003);
      tick();
      issue = 1; op_sel = '0; hi_en = 0; lo_en = 0; alu_lo_hi = 2'b01;
      #1;
      n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL mflo_stall_first got=%b want=1", stall); end
      for (int i = 0; i < 200; i++) begin
         if (done === 1'b1) begin ok = 1; break; end
         if (stall !== 1'b1) stall_ok = 0;
         if (i == 10) begin
            alu_lo_hi = 2'b00;
            #1;
            n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL alu_op_no_stall got=%b want=0", stall); end
            alu_lo_hi = 2'b01;
         end
         tick();
      end
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL mflo_timeout got=no_done want=done"); end
      n_cmp++; if (!stall_ok) begin n_bad++; $display("FAIL mflo_stall_hold got=dropped want=held"); end
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL mflo_stall_done got=%b want=0", stall); end
      n_cmp++; if (lohi_data !== 32'h00030000) begin n_bad++; $display("FAIL mflo_data got=%h want=00030000", lohi_data); end
      alu_lo_hi = 2'b10;
      #1;
      n_cmp++; if (lohi_data !== 32'h00000001) begin n_bad++; $display("FAIL mfhi_data got=%h want=00000001", lohi_data); end
      alu_lo_hi = 2'b11;
      #1;
      n_cmp++; if (lohi_data !== '0) begin n_bad++; $display("FAIL lohi_none got=%h want=0", lohi_data); end
      idle_inputs();
      tick();
   endtask

   task automatic test_flush();
      run_mult("prior", MULTU, 32'h70000009, 32'h00000010, 32'h00000007, 32'h00000090);
      present_mult(MULT, 32'hFFFFFFFD, 32'd5);
      tick();
      idle_inputs();
      repeat (9) tick();
      flush = 1;
      tick();
      flush = 0;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy got=%b want=0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL flush_done got=%b want=0", done); end
      repeat (ITERS + 3) begin
         tick();
         n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL flush_late_done got=%b want=0", done); end
      end
      n_cmp++; if (hi_out !== 32'h7) begin n_bad++; $display("FAIL flush_hi got=%h want=00000007", hi_out); end
      n_cmp++; if (lo_out !== 32'h90) begin n_bad++; $display("FAIL flush_lo got=%h want=00000090", lo_out); end
      // Flush in IDLE must block acceptance.
      present_mult(MULT, 32'd3, 32'd3);
      flush = 1;
      tick();
      idle_inputs();
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_idle_block got=%b want=0", busy); end
   endtask

   task automatic test_partial_en();
      present_mult(MULT, 32'd3, 32'd4);
      lo_en = 0;
      tick();
      idle_inputs();
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL partial_en_busy got=%b want=0", busy); end
      repeat (ITERS + 3) tick();
      n_cmp++; if (hi_out !== 32'h7 || lo_out !== 32'h90) begin
         n_bad++; $display("FAIL partial_en_hilo got=%h_%h want=00000007_00000090", hi_out, lo_out);
      end
   endtask

   task automatic test_reset_mid_run();
      present_mult(MULTU, 32'h12345678, 32'h9);
      tick();
      idle_inputs();
      repeat (5) tick();
      rst = 1;
      tick();
      rst = 0;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_run_busy got=%b want=0", busy); end
      n_cmp++; if (hi_out !== '0 || lo_out !== '0) begin
         n_bad++; $display("FAIL rst_run_hilo got=%h_%h want=0_0", hi_out, lo_out);
      end
      repeat (ITERS + 3) tick();
      n_cmp++; if (lo_out !== '0) begin n_bad++; $display("FAIL rst_run_late got=%h want=0", lo_out); end
   endtask

   task automatic test_back_to_back();
      int  cyc;
      bit  ok;
      bit  stall_ok = 1;
      present_mult(MULT, 32'd100, 32'hFFFFFFFE);
      tick();
      present_mult(MULT, 32'h00012345, 32'h00000100);
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         if (done === 1'b1) begin ok = 1; break; end
         if (stall !== 1'b1) stall_ok = 0;
         tick();
      end
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_first_timeout got=no_done want=done"); end
      n_cmp++; if (!stall_ok) begin n_bad++; $display("FAIL b2b_stall_hold got=dropped want=held"); end
      n_cmp++; if (hi_out !== 32'hFFFFFFFF || lo_out !== 32'hFFFFFF38) begin
         n_bad++; $display("FAIL b2b_first got=%h_%h want=ffffffff_ffffff38", hi_out, lo_out);
      end
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL b2b_stall_done got=%b want=0", stall); end
      tick();
      idle_inputs();
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_second_accept got=%b want=1", busy); end
      wait_done(cyc, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_second_timeout got=no_done want=done"); end
      n_cmp++; if (cyc != ITERS + 1) begin n_bad++; $display("FAIL b2b_second_latency got=%0d want=%0d", cyc, ITERS + 1); end
      n_cmp++; if (hi_out !== 32'h0 || lo_out !== 32'h01234500) begin
         n_bad++; $display("FAIL b2b_second got=%h_%h want=00000000_01234500", hi_out, lo_out);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_multu();
      test_mult_signed();
      test_mflo_stall();
      test_flush();
      test_partial_en();
      test_reset_mid_run();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
